// File: rtl/quad_sample_ctrl.sv
// quad_sample_ctrl: sampling sequencer for a two-channel quadrature encoder peripheral.
// On a programmable period it takes a coherent snapshot of both free-running encoder
// counts. It then publishes the snapshot plus the signed per-period deltas to the register
// bank with a one-cycle write strobe.
//
// Ports:
//   hba_clk, hba_reset   clock, asynchronous active-high reset
//   en, irq_en           sampling enable, interrupt enable
//   period               sample interval minus 1, in clocks
//   freeze               host read in progress; published outputs held
//   ack                  one-cycle host acknowledge; clears pending/overrun
//   count0, count1       free-running encoder counts
//   snap0, snap1         published snapshots
//   delta0, delta1       snapshot minus previous sample (modular)
//   wr_en                one-cycle register-bank load strobe
//   pending, overrun     handshake status
//   irq                  pending AND irq_en
module quad_sample_ctrl #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    hba_clk,
  input  logic                    hba_reset,
  input  logic                    en,
  input  logic                    irq_en,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    freeze,
  input  logic                    ack,
  input  logic [CNT_WIDTH-1:0]    count0,
  input  logic [CNT_WIDTH-1:0]    count1,
  output logic [CNT_WIDTH-1:0]    snap0,
  output logic [CNT_WIDTH-1:0]    snap1,
  output logic [CNT_WIDTH-1:0]    delta0,
  output logic [CNT_WIDTH-1:0]    delta1,
  output logic                    wr_en,
  output logic                    pending,
  output logic                    overrun,
  output logic                    irq
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [PERIOD_WIDTH-1:0] tick_q, tick_d;
  logic [CNT_WIDTH-1:0]    prev0_q, prev0_d, prev1_q, prev1_d;
  logic [CNT_WIDTH-1:0]    cur0_q, cur0_d, cur1_q, cur1_d;
  logic [CNT_WIDTH-1:0]    snap0_q, snap0_d, snap1_q, snap1_d;
  logic [CNT_WIDTH-1:0]    delta0_q, delta0_d, delta1_q, delta1_d;
  logic                    wr_en_q, wr_en_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;

  logic tick;
  logic publish;
  logic drop;

  // The tick counter only runs outside IDLE; reaching zero marks the sampling edge.
  assign tick    = (state_q != StIdle) && (tick_q == '0);
  assign publish = (state_q == StCapture) && en && !freeze;
  // A tick arriving while a capture is still held cannot be stored and is lost.
  assign drop    = (state_q == StCapture) && en && tick;

  always_comb begin
    if (state_q == StIdle) begin
      tick_d = en ? period : tick_q;
    end else if (tick) begin
      tick_d = period;
    end else begin
      tick_d = tick_q - PERIOD_WIDTH'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    prev0_d  = prev0_q;
    prev1_d  = prev1_q;
    cur0_d   = cur0_q;
    cur1_d   = cur1_q;
    snap0_d  = snap0_q;
    snap1_d  = snap1_q;
    delta0_d = delta0_q;
    delta1_d = delta1_q;
    wr_en_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          // Baseline for the first delta; not published.
          prev0_d = count0;
          prev1_d = count1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
        end else if (tick) begin
          cur0_d  = count0;
          cur1_d  = count1;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (!en) begin
          state_d = StIdle;
        end else if (!freeze) begin
          snap0_d  = cur0_q;
          snap1_d  = cur1_q;
          delta0_d = cur0_q - prev0_q;
          delta1_d = cur1_q - prev1_q;
          prev0_d  = cur0_q;
          prev1_d  = cur1_q;
          wr_en_d  = 1'b1;
          state_d  = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ack clears the status, but a coincident publish keeps pending, a coincident
  // drop forces overrun, and ack with publish leaves overrun untouched.
  always_comb begin
    overrun_d = overrun_q;
    if (ack && !publish) overrun_d = 1'b0;
    if (publish && pending_q && !ack) overrun_d = 1'b1;
    if (drop) overrun_d = 1'b1;
  end

  always_comb begin
    pending_d = pending_q;
    if (publish) begin
      pending_d = 1'b1;
    end else if (ack) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      prev0_q   <= '0;
      prev1_q   <= '0;
      cur0_q    <= '0;
      cur1_q    <= '0;
      snap0_q   <= '0;
      snap1_q   <= '0;
      delta0_q  <= '0;
      delta1_q  <= '0;
      wr_en_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      prev0_q   <= prev0_d;
      prev1_q   <= prev1_d;
      cur0_q    <= cur0_d;
      cur1_q    <= cur1_d;
      snap0_q   <= snap0_d;
      snap1_q   <= snap1_d;
      delta0_q  <= delta0_d;
      delta1_q  <= delta1_d;
      wr_en_q   <= wr_en_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign snap0   = snap0_q;
  assign snap1   = snap1_q;
  assign delta0  = delta0_q;
  assign delta1  = delta1_q;
  assign wr_en   = wr_en_q;
  assign pending = pending_q;
  assign overrun = overrun_q;
  assign irq     = pending_q & irq_en;

endmodule
